// File: rtl/uart_rx.sv
// uart_rx: Avalon-MM UART receiver with mid-bit sampling and a one-character holding register
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   avalon_read/write     host strobes; avalon_address 0 = DATA, 1 = CTRL
//   avalon_byteenable     only bit 0 qualifies CTRL writes
//   avalon_writedata      CTRL write data, bit 0 = IRQ_EN
//   avalon_readdata       zero-latency read data: [7:0] char, [8] VALID, [9] PERR, [10] FERR, [11] OVR, [12] IRQ_EN
//   avalon_waitrequest    tied to 0
//   status_irq            VALID & IRQ_EN
//   status_err            PERR | FERR | OVR
//   uart_rxd              serial input, idle high
// Define UART_RX_SYNC_EN to insert a 2-flop synchronizer on uart_rxd (adds 2 cycles of latency).
module uart_rx #(
    parameter int    BYTESIZE = 8,
    parameter string PARITY   = "NONE",
    parameter int    STOPSIZE = 1,
    parameter int    N_BIT    = 16,
    parameter int    N_LOG    = $clog2(N_BIT),
    parameter int    AAW      = 1,
    parameter int    ADW      = 32,
    parameter int    ABW      = ADW / 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           avalon_read,
    input  logic           avalon_write,
    input  logic [AAW-1:0] avalon_address,
    input  logic [ABW-1:0] avalon_byteenable,
    input  logic [ADW-1:0] avalon_writedata,
    output logic [ADW-1:0] avalon_readdata,
    output logic           avalon_waitrequest,
    output logic           status_irq,
    output logic           status_err,
    input  logic           uart_rxd
);
    localparam bit HAS_PAR = PARITY != "NONE";
    localparam bit ODD     = PARITY == "ODD";

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t              state, state_nx;
    logic                rxd;
    logic [N_LOG-1:0]    cnt;
    logic [3:0]          bit_cnt;
    logic [BYTESIZE-1:0] shreg;
    logic                perr_acc, ferr_acc, done;
    logic [7:0]          char_q, char_nx;
    logic                valid, perr, ferr, ovr, irq_en;
    logic                tick, last_data, last_stop, rd_data, wr_ctrl;
    logic                unused_bits;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge clk or posedge rst)
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], uart_rxd};
    assign rxd = sync[1];
`else
    assign rxd = uart_rxd;
`endif

    always_comb begin
        tick      = state != IDLE && cnt == '0;
        last_data = tick && state == DATA && bit_cnt == 4'(BYTESIZE - 1);
        last_stop = tick && state == STOP && bit_cnt == 4'(STOPSIZE - 1);
        state_nx  = state;
        case (state)
            IDLE:    if (!rxd) state_nx = START;
            START:   if (tick) state_nx = rxd ? IDLE : DATA;
            DATA:    if (last_data) state_nx = HAS_PAR ? PAR : STOP;
            PAR:     if (tick) state_nx = STOP;
            STOP:    if (last_stop) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    // Frame datapath. The per-frame error accumulators clear in IDLE; the buffer load
    // (done) happens on the first IDLE cycle, so it still sees the finished frame's values.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
            done     <= 1'b0;
        end else begin
            done    <= last_stop;
            cnt     <= state == IDLE ? N_LOG'(N_BIT / 2 - 1) : tick ? N_LOG'(N_BIT - 1) : cnt - 1'b1;
            bit_cnt <= state_nx != state ? 4'd0 : tick ? bit_cnt + 4'd1 : bit_cnt;
            if (tick && state == DATA) shreg <= {rxd, shreg[BYTESIZE-1:1]};
            if (state == IDLE) begin
                perr_acc <= 1'b0;
                ferr_acc <= 1'b0;
            end
            if (tick && state == PAR)  perr_acc <= ^shreg ^ rxd ^ ODD;
            if (tick && state == STOP) ferr_acc <= ferr_acc | ~rxd;
        end

    always_comb begin
        char_nx                 = '0;
        char_nx[BYTESIZE-1:0]   = shreg;
        rd_data = avalon_read && avalon_address == AAW'(0);
        wr_ctrl = avalon_write && avalon_address == AAW'(1) && avalon_byteenable[0];
    end

    // Holding register. A load in the same cycle as a DATA read wins; a DATA read
    // consumes the character, so it reads back as zero afterwards.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            char_q <= '0;
            valid  <= 1'b0;
            perr   <= 1'b0;
            ferr   <= 1'b0;
            ovr    <= 1'b0;
            irq_en <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en <= avalon_writedata[0];
            if (done) begin
                char_q <= char_nx;
                valid  <= 1'b1;
                perr   <= perr_acc;
                ferr   <= ferr_acc;
                ovr    <= !rd_data && (ovr || valid);
            end else if (rd_data) begin
                char_q <= '0;
                valid  <= 1'b0;
                perr   <= 1'b0;
                ferr   <= 1'b0;
                ovr    <= 1'b0;
            end
        end

    always_comb begin
        avalon_readdata       = '0;
        avalon_readdata[12:0] = {irq_en, ovr, ferr, perr, valid, char_q};
    end

    assign avalon_waitrequest = 1'b0;
    assign status_irq         = valid & irq_en;
    assign status_err         = perr | ferr | ovr;
    assign unused_bits        = ^{avalon_writedata, avalon_byteenable};
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx, one 8N1 and one 8E2 instance
`timescale 1ns/1ps
module tb_uart_rx;
    typedef struct packed {logic [31:0] rd; logic irq; logic err;} exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd[2], wr[2], rxd[2], wt[2], irq[2], err[2];
    logic [0:0]  addr[2];
    logic [3:0]  be[2];
    logic [31:0] wd[2], rdata[2];

    exp_t q0[$], q1[$];
    int   n_chk = 0, n_fail = 0;
    int   has_par[2] = '{0, 1};
    int   stops[2]   = '{1, 2};

    logic [7:0] m_char[2];
    bit         m_valid[2], m_perr[2], m_ferr[2], m_ovr[2], m_irq[2];

    always #5 clk = ~clk;

    uart_rx #(.PARITY("NONE"), .STOPSIZE(1)) dut0 (
        .clk(clk), .rst(rst), .avalon_read(rd[0]), .avalon_write(wr[0]),
        .avalon_address(addr[0]), .avalon_byteenable(be[0]), .avalon_writedata(wd[0]),
        .avalon_readdata(rdata[0]), .avalon_waitrequest(wt[0]), .status_irq(irq[0]),
        .status_err(err[0]), .uart_rxd(rxd[0]));

    uart_rx #(.PARITY("EVEN"), .STOPSIZE(2)) dut1 (
        .clk(clk), .rst(rst), .avalon_read(rd[1]), .avalon_write(wr[1]),
        .avalon_address(addr[1]), .avalon_byteenable(be[1]), .avalon_writedata(wd[1]),
        .avalon_readdata(rdata[1]), .avalon_waitrequest(wt[1]), .status_irq(irq[1]),
        .status_err(err[1]), .uart_rxd(rxd[1]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++)
            if (!rst && rd[i]) begin
                if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_read: dut%0d got %h expected no read", i, rdata[i]);
                end else begin
                    if (i == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk($sformatf("readdata%0d", i), rdata[i], e.rd);
                    chk($sformatf("irq%0d", i), 32'(irq[i]), 32'(e.irq));
                    chk($sformatf("err%0d", i), 32'(err[i]), 32'(e.err));
                    chk($sformatf("waitreq%0d", i), 32'(wt[i]), 32'd0);
                end
            end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_char[i] = 8'd0;
            m_valid[i] = 0; m_perr[i] = 0; m_ferr[i] = 0; m_ovr[i] = 0; m_irq[i] = 0;
        end
    endtask

    task automatic line(input int i, input logic v, input int cycles);
        rxd[i] = v;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // One frame: start, 8 data bits LSB first, optional even parity, stop bits.
    task automatic send(input int i, input logic [7:0] d, input bit bad_p, input bit bad_s);
        int bs = bad_s ? int'($urandom_range(0, stops[i] - 1)) : -1;
        line(i, 1'b0, 16);
        for (int k = 0; k < 8; k++) line(i, d[k], 16);
        if (has_par[i] != 0) line(i, (^d) ^ bad_p, 16);
        for (int s = 0; s < stops[i]; s++) line(i, s != bs, 16);
        if (bad_s) line(i, 1'b1, 16);
        if (m_valid[i]) m_ovr[i] = 1;
        m_char[i]  = d;
        m_valid[i] = 1;
        m_perr[i]  = has_par[i] != 0 && bad_p;
        m_ferr[i]  = bad_s;
    endtask

    task automatic rd_reg(input int i, input bit a);
        exp_t e;
        e.rd  = {19'd0, m_irq[i], m_ovr[i], m_ferr[i], m_perr[i], m_valid[i], m_char[i]};
        e.irq = m_valid[i] & m_irq[i];
        e.err = m_perr[i] | m_ferr[i] | m_ovr[i];
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
        if (!a) begin
            m_char[i] = 8'd0;
            m_valid[i] = 0; m_perr[i] = 0; m_ferr[i] = 0; m_ovr[i] = 0;
        end
        addr[i] = a;
        rd[i]   = 1'b1;
        @(posedge clk); #1;
        rd[i]   = 1'b0;
    endtask

    task automatic wr_reg(input int i, input bit a, input bit v, input bit b0);
        wd[i]    = $urandom;
        wd[i][0] = v;
        be[i]    = {3'($urandom), b0};
        addr[i]  = a;
        if (a && b0) m_irq[i] = v;
        wr[i] = 1'b1;
        @(posedge clk); #1;
        wr[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rd[i] = 0; wr[i] = 0; rxd[i] = 1; addr[i] = 0; be[i] = 0; wd[i] = 0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_irq0", 32'(irq[0]), 32'd0);
        chk("reset_err1", 32'(err[1]), 32'd0);
        rd_reg(0, 1'b1);
        rd_reg(1, 1'b0);

        wr_reg(0, 1'b1, 1'b1, 1'b1);
        send(0, 8'hA5, 0, 0);
        rd_reg(0, 1'b0);
        rd_reg(0, 1'b0);

        send(1, 8'h01, 1, 0);
        rd_reg(1, 1'b0);
        rd_reg(1, 1'b1);

        send(0, 8'h5A, 0, 1);
        rd_reg(0, 1'b0);

        wr_reg(0, 1'b1, 1'b0, 1'b1);
        send(0, 8'h11, 0, 0);
        send(0, 8'h22, 0, 0);
        rd_reg(0, 1'b0);

        send(1, 8'h33, 0, 0);
        send(1, 8'h44, 0, 0);
        rd_reg(1, 1'b0);

        wr_reg(0, 1'b0, 1'b1, 1'b1);
        wr_reg(0, 1'b1, 1'b1, 1'b0);
        line(0, 1'b0, 4);
        line(0, 1'b1, 20);
        rd_reg(0, 1'b1);

        line(0, 1'b0, 16);
        line(0, 1'b1, 16);
        line(0, 1'b0, 16);
        rst = 1'b1;
        rxd[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        line(0, 1'b1, 16);
        send(0, 8'h3C, 0, 0);
        rd_reg(0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int i = int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) wr_reg(i, 1'b1, 1'($urandom), 1'($urandom));
            send(i, 8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 2) != 0) rd_reg(i, 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) rd_reg(i, 1'b0);
        end
        rd_reg(0, 1'b0);
        rd_reg(1, 1'b0);

        repeat (5) @(posedge clk);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Avalon-MM UART receiver; counterpart of the existing Avalon UART transmitter, using the same frame parameters. It recovers asynchronous serial frames from `uart_rxd` by mid-bit sampling, checks parity and stop bits, and holds one received character in a register for the host to read. It drives `status_irq` and `status_err` to the system interrupt controller.

## Interface
- BYTESIZE, 8: data bits per frame, 5..8
- PARITY, "NONE": "EVEN", "ODD" or "NONE"
- STOPSIZE, 1: stop bits, 1 or 2
- N_BIT, 16: clock cycles per bit, at least 4, even
- N_LOG, $clog2(N_BIT): width of the baud counter
- AAW, 1: Avalon address width
- ADW, 32: Avalon data width
- ABW, ADW/8: byte enable width
- clk, in, 1: clock
- rst, in, 1: reset, asynchronous, active-high
- avalon_read, in, 1: read strobe
- avalon_write, in, 1: write strobe
- avalon_address, in, AAW: 0 = DATA, 1 = CTRL
- avalon_byteenable, in, ABW: byte enables; only bit 0 is used
- avalon_writedata, in, ADW: write data
- avalon_readdata, out, ADW: combinational read data
- avalon_waitrequest, out, 1: constant 0
- status_irq, out, 1: character-ready interrupt
- status_err, out, 1: sticky error flag
- uart_rxd, in, 1: serial input, idle high

## Operation
**Read data layout:** [7:0] character, [8] VALID, [9] PERR, [10] FERR, [11] OVR, [12] IRQ_EN. All other bits read 0.
- Reading DATA returns this layout, then clears VALID, PERR, FERR and OVR.
- Reading CTRL returns the same layout and clears nothing.
- Writing CTRL with byteenable[0]=1 sets IRQ_EN from writedata[0]. Writes to DATA are ignored.

**Character alignment:** the character is right-aligned in [BYTESIZE-1:0]. Unused upper bits read 0. Bits arrive LSB first.

**States:** IDLE, START, DATA, PAR, STOP.
- IDLE: when rxd=0, load the counter with N_BIT/2-1 and go to START.
- Counter: counts down by 1 per cycle. A sample pulse occurs at count 0, and the counter reloads N_BIT-1.
- START, at the sample pulse:
  - rxd=1: false start; go to IDLE. No flags change.
  - rxd=0: go to DATA.
- DATA: shift in BYTESIZE samples. Then go to PAR, or to STOP if PARITY="NONE".
- PAR: sample the parity bit and compare it with the computed parity. EVEN means the XOR of data and parity bit is 0. ODD means that XOR is 1.
- STOP: sample STOPSIZE stop bits. Any stop sample equal to 0 sets the frame's FERR.
- At the last stop sample, go to IDLE at once so a back-to-back start bit is caught.

**Buffer load** (the cycle after the last stop sample):
- character ← received data; VALID ← 1.
- PERR and FERR take this frame's result.
- If VALID was already 1 and no DATA read happens in the same cycle: OVR ← 1 and the old character is overwritten.
- Load coincident with a DATA read: the load wins. VALID stays 1 and OVR is not set.

**Status outputs:**
- status_irq = VALID & IRQ_EN.
- status_err = PERR | FERR | OVR.

## Timing
- Reset values:
  - state IDLE
  - character 0; VALID, PERR, FERR, OVR, IRQ_EN all 0
  - status_irq 0, status_err 0
  - avalon_readdata reflects the cleared registers, i.e. 0
- Reset asserted mid-frame aborts the frame. There is no partial load.
- Let t0 be the clock edge at which IDLE sees rxd=0.
  - Start sample: t0+N_BIT/2.
  - Bit k (k=1 is data LSB, counting through parity and stop bits) is sampled at t0+N_BIT/2+k·N_BIT.
  - VALID rises one cycle after the last stop sample.
- Read latency is 0: readdata is valid in the same cycle as avalon_read. Clearing takes effect at the next edge.
- With UART_RX_SYNC_EN, all sample times shift by +2 cycles.

## Configuration
- UART_RX_SYNC_EN defined:
  - uart_rxd passes through a 2-flop synchronizer (reset value 1) before the FSM.
  - Latency increases by 2 cycles.
  - Required whenever uart_rxd is asynchronous to clk.
- Undefined: the FSM samples uart_rxd directly.
- The field layout, flags and state machine are identical in both cases.

## Test plan
All scenarios use N_BIT=16.
- 8N1 frame 0xA5, IRQ_EN=1 → status_irq=1. Read DATA = 0x000011A5; next read DATA = 0x00001000.
- EVEN parity, data 0x01 with parity bit 0 → read DATA = 0x00000301, status_err=1 before the read and 0 after it.
- Stop bit driven 0 → FERR. Read DATA bits [10:8] = 3'b101.
- Two frames 0x11 then 0x22 with no read between them → read DATA = 0x00000922. STOPSIZE=2 back-to-back frames are received without loss.
- rxd low for 4 cycles only → stays in IDLE. VALID=0 and no flags change.
- Reset asserted during DATA, then a clean frame 0x3C → read DATA returns exactly 0x3C with VALID=1 and no error flags.
